// File: rtl/mio_pkg.sv
// Shared address map, FSM state encoding and target-select type for the MIO bus responder.
package mio_pkg;

    localparam int RAM_DEPTH = 1024;
    localparam int RAM_AW    = $clog2(RAM_DEPTH);

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK     = 32'hFFFF_F000;
    localparam logic [31:0] PERIPH_BASE  = 32'hF000_0000;
    localparam logic [31:0] GPIO_OFFSET  = 32'h0000_0000;
    localparam logic [31:0] TIMER_OFFSET = 32'h0000_0004;
    localparam logic [31:0] GPIO_ADDR    = PERIPH_BASE + GPIO_OFFSET;
    localparam logic [31:0] TIMER_ADDR   = PERIPH_BASE + TIMER_OFFSET;

    // Byte-offset bits are never decoded, so matching is done on word addresses.
    localparam logic [29:0] RAM_WBASE  = RAM_BASE[31:2];
    localparam logic [29:0] RAM_WMASK  = RAM_MASK[31:2];
    localparam logic [29:0] GPIO_WORD  = GPIO_ADDR[31:2];
    localparam logic [29:0] TIMER_WORD = TIMER_ADDR[31:2];

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_RAM      = 2'd0,
        SEL_GPIO     = 2'd1,
        SEL_TIMER    = 2'd2,
        SEL_UNMAPPED = 2'd3
    } sel_t;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: word address -> RAM / GPIO / TIMER / UNMAPPED.
// The timer region only decodes when MIO_TIMER_EN is defined.
module mio_addr_decode
    import mio_pkg::*;
(
    input  logic [29:0] word_addr,
    output sel_t        sel
);

    always_comb begin
        sel = SEL_UNMAPPED;
        if ((word_addr & RAM_WMASK) == RAM_WBASE) begin
            sel = SEL_RAM;
        end else if (word_addr == GPIO_WORD) begin
            sel = SEL_GPIO;
        end
`ifdef MIO_TIMER_EN
        else if (word_addr == TIMER_WORD) begin
            sel = SEL_TIMER;
        end
`endif
    end

endmodule

// File: rtl/mio_bus_responder.sv
// MIO bus responder: latches CPU requests and serves RAM, GPIO and (with MIO_TIMER_EN) a free-running timer,
// answering each request with a one-cycle mio_ready pulse.
module mio_bus_responder
    import mio_pkg::*;
#(
    parameter int RAM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mio,
    input  logic        mem_w,
    input  logic [31:0] addr_bus,
    input  logic [31:0] data_from_cpu,
    output logic [31:0] data_to_cpu,
    output logic        mio_ready,
    output logic        bus_err,
    output logic [9:0]  ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    input  logic [31:0] ram_dout,
    input  logic [15:0] sw_in,
    output logic [31:0] gpio_out,
    output logic [1:0]  dbg_state
);

    localparam logic [3:0] WAIT_INIT = 4'(RAM_WAIT);

    state_t             state_q, state_d;
    sel_t               dec_sel, sel_q;
    logic               we_q;
    logic [RAM_AW-1:0]  waddr_q;
    logic [31:0]        data_q;
    logic [3:0]         cnt_q;
    logic [31:0]        periph_rdata;
    logic               unused_byte_bits;

    assign unused_byte_bits = &{1'b0, addr_bus[1:0]};

    mio_addr_decode u_decode (
        .word_addr (addr_bus[31:2]),
        .sel       (dec_sel)
    );

`ifdef MIO_TIMER_EN
    logic [31:0] timer_q;

    // A CPU write lands on the RESP edge and takes priority over the increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (state_q == ST_RESP && we_q && sel_q == SEL_TIMER) begin
            timer_q <= data_q;
        end else begin
            timer_q <= timer_q + 32'd1;
        end
    end
`endif

    always_comb begin
        periph_rdata = '0;
        case (dec_sel)
            SEL_GPIO: periph_rdata = {16'h0000, sw_in};
`ifdef MIO_TIMER_EN
            SEL_TIMER: periph_rdata = timer_q;
`endif
            default: periph_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mio_ready = 1'b0;
        bus_err   = 1'b0;
        ram_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_mio) begin
                    state_d = (dec_sel == SEL_RAM) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                ram_we = we_q && (cnt_q == WAIT_INIT);
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                mio_ready = 1'b1;
                bus_err   = (sel_q == SEL_UNMAPPED);
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, wait counter, read-data capture and GPIO register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel_q       <= SEL_RAM;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            data_to_cpu <= '0;
            gpio_out    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cpu_mio) begin
                        sel_q   <= dec_sel;
                        we_q    <= mem_w;
                        waddr_q <= addr_bus[RAM_AW+1:2];
                        data_q  <= data_from_cpu;
                        cnt_q   <= WAIT_INIT;
                        if (dec_sel != SEL_RAM && !mem_w) begin
                            data_to_cpu <= periph_rdata;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1 && !we_q) begin
                        data_to_cpu <= ram_dout;
                    end
                end
                ST_RESP: begin
                    if (we_q && sel_q == SEL_GPIO) begin
                        gpio_out <= data_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr  = waddr_q;
    assign ram_din   = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Directed self-checking bench for mio_bus_responder (RAM_WAIT=2) with a 1-cycle-latency RAM model.
module tb_mio_bus_responder;

    localparam int RW = 2;

    logic        clk;
    logic        reset;
    logic        cpu_mio;
    logic        mem_w;
    logic [31:0] addr_bus;
    logic [31:0] data_from_cpu;
    logic [31:0] data_to_cpu;
    logic        mio_ready;
    logic        bus_err;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [15:0] sw_in;
    logic [31:0] gpio_out;
    logic [1:0]  dbg_state;

    int n_compared;
    int n_mismatched;

    logic [31:0] mem [0:1023];

    mio_bus_responder #(.RAM_WAIT(RW)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_mio       (cpu_mio),
        .mem_w         (mem_w),
        .addr_bus      (addr_bus),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .mio_ready     (mio_ready),
        .bus_err       (bus_err),
        .ram_addr      (ram_addr),
        .ram_din       (ram_din),
        .ram_we        (ram_we),
        .ram_dout      (ram_dout),
        .sw_in         (sw_in),
        .gpio_out      (gpio_out),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int we_cnt, output logic [9:0] we_a, output logic [31:0] we_d);
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_w = we; addr_bus = a; data_from_cpu = d;
        lat = -1; err = 1'b0; rd = '0; we_cnt = 0; we_a = '0; we_d = '0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ram_we) begin
                we_cnt++; we_a = ram_addr; we_d = ram_din;
            end
            if (mio_ready) begin
                lat = k; err = bus_err; rd = data_to_cpu;
                break;
            end
        end
        cpu_mio = 1'b0; mem_w = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            cpu_mio = 1'($urandom); mem_w = 1'($urandom);
            addr_bus = $urandom; data_from_cpu = $urandom; sw_in = 16'($urandom);
        end
        @(posedge clk); #1;
        n_compared++; if (mio_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mio_ready got %0h want 0", mio_ready); end
        n_compared++; if (bus_err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_bus_err got %0h want 0", bus_err); end
        n_compared++; if (ram_we !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ram_we got %0h want 0", ram_we); end
        n_compared++; if (data_to_cpu !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_data got %08h want 0", data_to_cpu); end
        n_compared++; if (ram_addr !== 10'h0) begin n_mismatched++; $display("[TB] FAIL reset_ram_addr got %0h want 0", ram_addr); end
        n_compared++; if (ram_din !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_ram_din got %08h want 0", ram_din); end
        n_compared++; if (gpio_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL reset_gpio got %08h want 0", gpio_out); end
        n_compared++; if (dbg_state !== 2'd0) begin n_mismatched++; $display("[TB] FAIL reset_state got %0d want 0", dbg_state); end
        // Release reset and present a GPIO read in the same step: the first edge must sample it.
        sw_in = 16'h00FF;
        reset = 1'b1; cpu_mio = 1'b1; mem_w = 1'b0; addr_bus = 32'hF000_0000; data_from_cpu = '0;
        @(posedge clk); #1;
        n_compared++; if (mio_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_ready got %0h want 1", mio_ready); end
        n_compared++; if (data_to_cpu !== 32'h0000_00FF) begin n_mismatched++; $display("[TB] FAIL post_reset_gpio_rd got %08h want 000000ff", data_to_cpu); end
        cpu_mio = 1'b0;
    endtask

    task automatic test_ram();
        int lat; logic err; logic [31:0] rd; int wc; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, err, rd, wc, wa, wd);
        n_compared++; if (lat !== 1 + RW) begin n_mismatched++; $display("[TB] FAIL ram_wr_latency got %0d want %0d", lat, 1 + RW); end
        n_compared++; if (wc !== 1) begin n_mismatched++; $display("[TB] FAIL ram_wr_we_pulses got %0d want 1", wc); end
        n_compared++; if (wa !== 10'd4) begin n_mismatched++; $display("[TB] FAIL ram_wr_addr got %0h want 4", wa); end
        n_compared++; if (wd !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL ram_wr_din got %08h want deadbeef", wd); end
        n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ram_wr_bus_err got %0h want 0", err); end
        n_compared++; if (rd !== 32'h0000_00FF) begin n_mismatched++; $display("[TB] FAIL ram_wr_keeps_data got %08h want 000000ff", rd); end
        do_req(1'b0, 32'h0000_0010, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (lat !== 1 + RW) begin n_mismatched++; $display("[TB] FAIL ram_rd_latency got %0d want %0d", lat, 1 + RW); end
        n_compared++; if (rd !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL ram_rd_data got %08h want deadbeef", rd); end
        n_compared++; if (wc !== 0) begin n_mismatched++; $display("[TB] FAIL ram_rd_we_pulses got %0d want 0", wc); end
        do_req(1'b1, 32'h0000_0FFC, 32'h1234_5678, lat, err, rd, wc, wa, wd);
        n_compared++; if (wa !== 10'h3FF) begin n_mismatched++; $display("[TB] FAIL ram_top_wr_addr got %0h want 3ff", wa); end
        do_req(1'b0, 32'h0000_0FFF, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (rd !== 32'h1234_5678) begin n_mismatched++; $display("[TB] FAIL ram_top_rd_data got %08h want 12345678", rd); end
        n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ram_top_bus_err got %0h want 0", err); end
    endtask

    task automatic test_gpio();
        int lat; logic err; logic [31:0] rd; int wc; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b1, 32'hF000_0000, 32'h0000_A5A5, lat, err, rd, wc, wa, wd);
        n_compared++; if (lat !== 1) begin n_mismatched++; $display("[TB] FAIL gpio_wr_latency got %0d want 1", lat); end
        n_compared++; if (gpio_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL gpio_before_resp_edge got %08h want 0", gpio_out); end
        @(posedge clk); #1;
        n_compared++; if (gpio_out !== 32'h0000_A5A5) begin n_mismatched++; $display("[TB] FAIL gpio_after_resp got %08h want 0000a5a5", gpio_out); end
        sw_in = 16'h1234;
        do_req(1'b0, 32'hF000_0000, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (rd !== 32'h0000_1234) begin n_mismatched++; $display("[TB] FAIL gpio_rd_data got %08h want 00001234", rd); end
        n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL gpio_rd_bus_err got %0h want 0", err); end
    endtask

    task automatic test_unmapped();
        int lat; logic err; logic [31:0] rd; int wc; logic [9:0] wa; logic [31:0] wd;
        do_req(1'b0, 32'h8000_0000, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (lat !== 1) begin n_mismatched++; $display("[TB] FAIL unmap_rd_latency got %0d want 1", lat); end
        n_compared++; if (err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL unmap_rd_bus_err got %0h want 1", err); end
        n_compared++; if (rd !== 32'h0) begin n_mismatched++; $display("[TB] FAIL unmap_rd_data got %08h want 0", rd); end
        do_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, err, rd, wc, wa, wd);
        n_compared++; if (err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL unmap_wr_bus_err got %0h want 1", err); end
        n_compared++; if (wc !== 0) begin n_mismatched++; $display("[TB] FAIL unmap_wr_ram_we got %0d want 0", wc); end
        @(posedge clk); #1;
        n_compared++; if (gpio_out !== 32'h0000_A5A5) begin n_mismatched++; $display("[TB] FAIL unmap_wr_gpio got %08h want 0000a5a5", gpio_out); end
        do_req(1'b0, 32'h0000_1000, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (lat !== 1 || err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ram_end_boundary lat=%0d err=%0h want lat=1 err=1", lat, err); end
    endtask

    task automatic test_timer();
        int lat; logic err; logic [31:0] rd; int wc; logic [9:0] wa; logic [31:0] wd;
`ifdef MIO_TIMER_EN
        do_req(1'b1, 32'hF000_0004, 32'hFFFF_FFFE, lat, err, rd, wc, wa, wd);
        n_compared++; if (err !== 1'b0) begin n_mismatched++; $display("[TB] FAIL timer_wr_bus_err got %0h want 0", err); end
        repeat (2) @(posedge clk);
        do_req(1'b0, 32'hF000_0004, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (rd !== 32'h0000_0000) begin n_mismatched++; $display("[TB] FAIL timer_wrap got %08h want 00000000", rd); end
        n_compared++; if (err !== 1'b0 || lat !== 1) begin n_mismatched++; $display("[TB] FAIL timer_rd_resp err=%0h lat=%0d want err=0 lat=1", err, lat); end
`else
        do_req(1'b0, 32'hF000_0004, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (err !== 1'b1) begin n_mismatched++; $display("[TB] FAIL no_timer_bus_err got %0h want 1", err); end
        n_compared++; if (rd !== 32'h0 || lat !== 1) begin n_mismatched++; $display("[TB] FAIL no_timer_rd data=%08h lat=%0d want data=0 lat=1", rd, lat); end
`endif
    endtask

    task automatic test_back_to_back();
        int first_k; int second_k; logic [31:0] d1; logic [31:0] d2;
        first_k = -1; second_k = -1; d1 = '0; d2 = '0;
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_w = 1'b0; addr_bus = 32'h0000_0010;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (mio_ready) begin
                if (first_k < 0) begin
                    first_k = k; d1 = data_to_cpu; addr_bus = 32'h0000_0FFC;
                end else begin
                    second_k = k; d2 = data_to_cpu;
                    break;
                end
            end
        end
        cpu_mio = 1'b0;
        n_compared++; if (first_k !== 1 + RW) begin n_mismatched++; $display("[TB] FAIL b2b_first_latency got %0d want %0d", first_k, 1 + RW); end
        n_compared++; if (second_k - first_k !== 2 + RW) begin n_mismatched++; $display("[TB] FAIL b2b_spacing got %0d want %0d", second_k - first_k, 2 + RW); end
        n_compared++; if (d1 !== 32'hDEAD_BEEF) begin n_mismatched++; $display("[TB] FAIL b2b_data1 got %08h want deadbeef", d1); end
        n_compared++; if (d2 !== 32'h1234_5678) begin n_mismatched++; $display("[TB] FAIL b2b_data2 got %08h want 12345678", d2); end
    endtask

    task automatic test_abort();
        int lat; logic err; logic [31:0] rd; int wc; logic [9:0] wa; logic [31:0] wd;
        int ready_seen;
        @(posedge clk); #1;
        cpu_mio = 1'b1; mem_w = 1'b1; addr_bus = 32'h0000_0020; data_from_cpu = 32'h0BAD_F00D;
        repeat (2) @(posedge clk);
        #1;
        n_compared++; if (dbg_state !== 2'd1) begin n_mismatched++; $display("[TB] FAIL abort_in_wait got %0d want 1", dbg_state); end
        reset = 1'b0;
        #1;
        n_compared++; if (dbg_state !== 2'd0 || mio_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL abort_state state=%0d ready=%0h want 0/0", dbg_state, mio_ready); end
        n_compared++; if (gpio_out !== 32'h0) begin n_mismatched++; $display("[TB] FAIL abort_gpio_cleared got %08h want 0", gpio_out); end
        cpu_mio = 1'b0; mem_w = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        ready_seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (mio_ready) ready_seen++;
        end
        n_compared++; if (ready_seen !== 0) begin n_mismatched++; $display("[TB] FAIL abort_no_ready got %0d pulses want 0", ready_seen); end
        do_req(1'b0, 32'h0000_0020, 32'h0, lat, err, rd, wc, wa, wd);
        n_compared++; if (rd !== 32'h0BAD_F00D) begin n_mismatched++; $display("[TB] FAIL abort_write_kept got %08h want 0badf00d", rd); end
        n_compared++; if (lat !== 1 + RW) begin n_mismatched++; $display("[TB] FAIL abort_recovery_latency got %0d want %0d", lat, 1 + RW); end
    endtask

    initial begin
        n_compared = 0; n_mismatched = 0;
        reset = 1'b0; cpu_mio = 1'b0; mem_w = 1'b0;
        addr_bus = '0; data_from_cpu = '0; sw_in = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        test_reset();
        test_ram();
        test_gpio();
        test_unmapped();
        test_timer();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder that answers the multi-cycle CPU's MIO bus requests. It latches each request, decodes the address into on-chip RAM, a GPIO register or an optional timer, and returns read data. It signals completion with a one-cycle `mio_ready` pulse. It sits between the CPU's `CPU_MIO`/`mem_w`/address/data outputs and the block RAM plus board I/O.

## Interface
- `RAM_WAIT`, default 1: RAM access cycles before response. Legal values are 1 to 15.
- `clk` in 1: single clock; all logic updates on the rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 resets the block.
- `cpu_mio` in 1: request strobe from the CPU. The CPU holds the request until it sees `mio_ready`.
- `mem_w` in 1: 1 = write, 0 = read. Sampled with the request.
- `addr_bus` in 32: byte address. `addr_bus[1:0]` is ignored.
- `data_from_cpu` in 32: write data.
- `data_to_cpu` out 32: read data. Valid while `mio_ready`=1.
- `mio_ready` out 1: one-cycle completion pulse.
- `bus_err` out 1: pulses together with `mio_ready` on an unmapped access.
- `ram_addr` out 10: RAM word address, equal to `addr[11:2]`.
- `ram_din` out 32: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_dout` in 32: RAM read data. Valid `RAM_WAIT` cycles after `ram_addr`.
- `sw_in` in 16: board switches.
- `gpio_out` out 32: LED/GPIO register.
- `dbg_state` out 2: current FSM state encoding.

## Operation
- Address map:
  - 0x0000_0000–0x0000_0FFF: RAM.
  - 0xF000_0000: GPIO. Write loads `gpio_out`. Read returns {16'b0, `sw_in`}.
  - 0xF000_0004: timer (see Configuration).
  - Anything else: unmapped. Writes are dropped, reads return 0, `bus_err`=1 in RESP.
- FSM states are IDLE(0), WAIT(1), RESP(2).
- IDLE with `cpu_mio`=1:
  - Latch address, data and `mem_w`.
  - RAM target: go to WAIT and load the wait counter with `RAM_WAIT`.
  - GPIO, timer or unmapped target: go to RESP.
- WAIT:
  - `ram_addr` and `ram_din` come from the latch.
  - `ram_we`=1 only in the first WAIT cycle, and only for writes.
  - The counter decrements each cycle. At 1, go to RESP and capture `ram_dout` into `data_to_cpu`.
- RESP:
  - `mio_ready`=1 for exactly one cycle.
  - Peripheral writes take effect on the RESP clock edge; `data_to_cpu` holds the read value.
  - Next state is always IDLE.
- `cpu_mio` is ignored outside IDLE. A request held high in the cycle after RESP is treated as a new request, so back-to-back accesses are legal.
- `data_to_cpu` holds its last value until the next read response. Write responses leave it unchanged.

## Timing
- Request sampled in IDLE at cycle N:
  - Peripheral or unmapped: `mio_ready` at cycle N+1.
  - RAM: `mio_ready` at cycle N+1+`RAM_WAIT`.
- Minimum request spacing is 2 cycles for peripherals and 2+`RAM_WAIT` cycles for RAM.
- Values while `reset`=0: `mio_ready`, `bus_err`, `ram_we` = 0; `data_to_cpu`, `ram_addr`, `ram_din`, `gpio_out`, timer = 0; state = IDLE.
- Reset mid-transaction aborts immediately and no `mio_ready` is issued. A RAM write already strobed is not undone.
- Reset release: the first request can be sampled on the first rising edge with `reset`=1.

## Configuration
- `MIO_TIMER_EN` defined:
  - 32-bit timer at 0xF000_0004 that increments every cycle.
  - Read returns the current count.
  - Write loads `data_from_cpu`. Load wins over increment; the value is load+1 the following cycle.
  - 0xFFFF_FFFF wraps to 0.
- `MIO_TIMER_EN` undefined: no timer logic. 0xF000_0004 is unmapped (read 0, `bus_err`=1).

## Structure
- Shared package `mio_pkg`:
  - Region base addresses and masks.
  - Register offsets.
  - FSM state typedef with fixed encodings 0/1/2.
  - RAM depth constant (1024).
- One sub-module, `mio_addr_decode`: combinational; maps address to a {RAM, GPIO, TIMER, UNMAPPED} select. It honours `MIO_TIMER_EN`.

## Test plan
- Reset: hold `reset`=0 with random inputs -> all outputs 0 and `dbg_state`=0. Release, then GPIO read -> `mio_ready` at N+1.
- RAM, `RAM_WAIT`=2: write 0xDEADBEEF to 0x0000_0010 -> `ram_we` pulses once with `ram_addr`=4 and `mio_ready` at N+3. Read back -> `data_to_cpu`=0xDEADBEEF with `mio_ready`.
- GPIO: write 0x0000_A5A5 to 0xF000_0000 -> `gpio_out`=0x0000_A5A5 after RESP. With `sw_in`=0x1234, read -> 0x0000_1234.
- Unmapped: read 0x8000_0000 -> `mio_ready` and `bus_err` together at N+1, `data_to_cpu`=0. Write -> no state change.
- Timer (`MIO_TIMER_EN`): write 0xFFFF_FFFE, then read 2 cycles later -> wrapped value 0x0000_0000 or later per cycle count. Without the macro, the same read asserts `bus_err`.
- Back-to-back and abort: hold `cpu_mio` high across two RAM reads -> two `mio_ready` pulses spaced 2+`RAM_WAIT` cycles. Assert `reset` in WAIT -> no `mio_ready` and return to IDLE.
